// File: rtl/filter_param_loader.sv
// filter_param_loader: stages per-transducer duty/phase offsets from BRAM
// into shadow registers and commits them to filter once its datapath is empty.
module filter_param_loader #(
    parameter int WIDTH      = 13,
    parameter int DEPTH      = 249,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    UPDATE_REQ,
    output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
    input  logic [31:0]             BRAM_DATA,
    input  logic                    DIN_VALID,
    input  logic                    DOUT_VALID,
    output logic signed [WIDTH:0]   FILTER_DUTY  [DEPTH],
    output logic signed [WIDTH:0]   FILTER_PHASE [DEPTH],
    output logic                    BUSY,
    output logic                    DONE
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        COMMIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t state_q;
    state_t state_cur;
    state_t state_n;

    logic                  pend_q;
    logic [9:0]            cnt_q;
    logic                  iss_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  v1_q;
    logic                  v2_q;
    logic [ADDR_WIDTH-1:0] i1_q;
    logic [ADDR_WIDTH-1:0] i2_q;
    logic                  done_q;

    logic signed [WIDTH:0] sh_duty  [DEPTH];
    logic signed [WIDTH:0] sh_phase [DEPTH];

    logic drained;
    logic last_cap;
    logic start;
    logic commit;
    logic pend_clr;
    logic unused_bram;

    assign unused_bram = ^{BRAM_DATA[31:17+WIDTH], BRAM_DATA[15:WIDTH+1]};

    assign drained  = (cnt_q == '0) && !DIN_VALID;
    assign last_cap = v2_q && (i2_q == LAST);

    assign BRAM_ADDR = addr_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;

    // The commit cycle is the DRAIN cycle in which the filter is empty.
    always_comb begin
        state_cur = state_q;
        if (state_q == DRAIN && drained) begin
            state_cur = COMMIT;
        end
    end

    always_comb begin
        state_n  = state_cur;
        start    = 1'b0;
        commit   = 1'b0;
        pend_clr = 1'b0;
        unique case (state_cur)
            IDLE: begin
                if (UPDATE_REQ || pend_q) begin
                    state_n  = LOAD;
                    start    = 1'b1;
                    pend_clr = 1'b1;
                end
            end
            LOAD: begin
                if (last_cap) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                state_n = DRAIN;
            end
            COMMIT: begin
                commit = 1'b1;
                if (pend_q || UPDATE_REQ) begin
                    state_n  = LOAD;
                    start    = 1'b1;
                    pend_clr = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            done_q  <= commit;
            if (pend_clr) begin
                pend_q <= 1'b0;
            end else if (UPDATE_REQ && state_cur != IDLE) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Beats in flight inside filter; saturates at both ends.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            unique case ({DIN_VALID, DOUT_VALID})
                2'b10: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                2'b01: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            iss_q  <= 1'b0;
            addr_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            i1_q   <= '0;
            i2_q   <= '0;
        end else begin
            if (start) begin
                iss_q  <= 1'b1;
                addr_q <= '0;
            end else if (iss_q) begin
                if (addr_q == LAST) begin
                    iss_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            // Index travels alongside the 2-cycle BRAM read.
            v1_q <= iss_q;
            i1_q <= addr_q;
            v2_q <= v1_q;
            i2_q <= i1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                sh_duty[i]      <= '0;
                sh_phase[i]     <= '0;
                FILTER_DUTY[i]  <= '0;
                FILTER_PHASE[i] <= '0;
            end
        end else begin
            if (v2_q) begin
                sh_duty[i2_q]  <= BRAM_DATA[WIDTH:0];
                sh_phase[i2_q] <= BRAM_DATA[16+WIDTH:16];
            end
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    FILTER_DUTY[i]  <= sh_duty[i];
                    FILTER_PHASE[i] <= sh_phase[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_param_loader.sv
// tb_filter_param_loader: directed bench with a 2-cycle BRAM model and a
// fixed-latency stand-in for the filter valid pipe.
module tb_filter_param_loader;

    localparam int W  = 13;
    localparam int D  = 249;
    localparam int AW = 8;
    localparam int L  = 8;

    typedef struct {
        int          idx;
        logic [31:0] word;
        int          exp_d;
        int          exp_p;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 RST;
    logic                 UPDATE_REQ;
    logic                 DIN_VALID;
    logic                 DOUT_VALID;
    logic                 dout_extra;
    logic                 BUSY;
    logic                 DONE;
    logic [AW-1:0]        BRAM_ADDR;
    logic [31:0]          BRAM_DATA;
    logic signed [W:0]    FILTER_DUTY  [D];
    logic signed [W:0]    FILTER_PHASE [D];

    logic [31:0] mem [256];
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [L-1:0] dsr = '0;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    filter_param_loader #(
        .WIDTH(W),
        .DEPTH(D),
        .ADDR_WIDTH(AW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .UPDATE_REQ(UPDATE_REQ),
        .BRAM_ADDR(BRAM_ADDR),
        .BRAM_DATA(BRAM_DATA),
        .DIN_VALID(DIN_VALID),
        .DOUT_VALID(DOUT_VALID),
        .FILTER_DUTY(FILTER_DUTY),
        .FILTER_PHASE(FILTER_PHASE),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        rd1 <= mem[BRAM_ADDR];
        rd2 <= rd1;
        dsr <= {dsr[L-2:0], DIN_VALID};
    end

    assign BRAM_DATA  = rd2;
    assign DOUT_VALID = dsr[L-1] | dout_extra;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic req(output int t);
        step();
        UPDATE_REQ = 1'b1;
        t = cyc;
        step();
        UPDATE_REQ = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at, output int changes);
        logic signed [W:0] d0;
        logic signed [W:0] p0;
        d0      = FILTER_DUTY[D-1];
        p0      = FILTER_PHASE[D-1];
        at      = -1;
        changes = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (DONE) begin
                at = cyc;
                break;
            end
            if (FILTER_DUTY[D-1] !== d0 || FILTER_PHASE[D-1] !== p0) begin
                changes++;
            end
        end
    endtask

    task automatic stream(input int s, input int n);
        goto(s);
        DIN_VALID = 1'b1;
        repeat (n) step();
        DIN_VALID = 1'b0;
    endtask

    function automatic logic [31:0] pk(input int d, input int p);
        logic [31:0] w;
        w        = '0;
        w[13:0]  = d[13:0];
        w[29:16] = p[13:0];
        return w;
    endfunction

    function automatic int duty_ne(input int v);
        int n;
        n = 0;
        for (int i = 0; i < D; i++) begin
            if (int'(FILTER_DUTY[i]) != v) n++;
        end
        return n;
    endfunction

    function automatic int phase_ne(input int v);
        int n;
        n = 0;
        for (int i = 0; i < D; i++) begin
            if (int'(FILTER_PHASE[i]) != v) n++;
        end
        return n;
    endfunction

    vec_t pv [5];
    vec_t sv [4];

    initial begin
        int t;
        int t2;
        int at;
        int ch;

        pv[0] = '{0,   pk(0, 0),       0,   0};
        pv[1] = '{1,   pk(1, -1),      1,   -1};
        pv[2] = '{100, pk(100, -100),  100, -100};
        pv[3] = '{247, pk(247, -247),  247, -247};
        pv[4] = '{248, pk(248, -248),  248, -248};

        sv[0] = '{0,   {2'b11, 14'h1FFF, 2'b11, 14'h2000}, -8192, 8191};
        sv[1] = '{1,   {2'b11, 14'h0001, 2'b11, 14'h3FFF}, -1,    1};
        sv[2] = '{17,  {2'b00, 14'h2000, 2'b00, 14'h1FFF}, 8191,  -8192};
        sv[3] = '{248, {2'b10, 14'h3FFF, 2'b01, 14'h0000}, 0,     -1};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        RST        = 1'b1;
        UPDATE_REQ = 1'b0;
        DIN_VALID  = 1'b0;
        dout_extra = 1'b0;

        // Reset
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_duty_nonzero", duty_ne(0), 0);
        chk("rst_phase_nonzero", phase_ne(0), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_addr", int'(BRAM_ADDR), 0);

        // Load with no traffic
        for (int i = 0; i < D; i++) mem[i] = pk(i, -i);
        req(t);
        @(negedge CLK);
        chk("load_busy_t1", int'(BUSY), 1);
        chk("load_addr_t1", int'(BRAM_ADDR), 0);
        goto(t + 11);
        @(negedge CLK);
        chk("load_addr_t11", int'(BRAM_ADDR), 10);
        chk("load_old_duty", int'(FILTER_DUTY[D-1]), 0);
        wait_done(400, at, ch);
        chk("load_done_cycle", at - t, 253);
        chk("load_stable_before", ch, 0);
        chk("load_busy_at_done", int'(BUSY), 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("load_duty[%0d]", pv[k].idx),
                int'(FILTER_DUTY[pv[k].idx]), pv[k].exp_d);
            chk($sformatf("load_phase[%0d]", pv[k].idx),
                int'(FILTER_PHASE[pv[k].idx]), pv[k].exp_p);
        end
        chk("load_phase248_raw", int'(FILTER_PHASE[D-1][W:0]), 'h3F08);
        step();
        @(negedge CLK);
        chk("load_done_width", int'(DONE), 0);
        chk("load_addr_hold", int'(BRAM_ADDR), D - 1);

        // Commit deferral while a stream is in flight
        for (int i = 0; i < D; i++) mem[i] = pk(7, -7);
        req(t);
        fork
            stream(t + 200, 249);
            wait_done(700, at, ch);
        join
        chk("defer_done_cycle", at - t, 200 + L + 248 + 2);
        chk("defer_stable_before", ch, 0);
        chk("defer_duty_new", duty_ne(7), 0);
        chk("defer_phase_new", phase_ne(-7), 0);

        // Spurious DOUT_VALID at count 0 must not wrap the counter
        step();
        dout_extra = 1'b1;
        repeat (3) step();
        dout_extra = 1'b0;
        for (int i = 0; i < D; i++) mem[i] = pk(3, 4);
        req(t);
        wait_done(400, at, ch);
        chk("underflow_done_cycle", at - t, 253);
        chk("underflow_duty", duty_ne(3), 0);

        // Pending request merged behind an active load
        for (int i = 0; i < D; i++) mem[i] = pk(i, -i);
        req(t);
        goto(t + 50);
        for (int i = 0; i < D; i++) mem[i] = pk(1000, 0);
        UPDATE_REQ = 1'b1;
        step();
        UPDATE_REQ = 1'b0;
        wait_done(400, at, ch);
        chk("pend_done1_cycle", at - t, 253);
        chk("pend_busy_after1", int'(BUSY), 1);
        chk("pend_addr_restart", int'(BRAM_ADDR), 0);
        wait_done(400, at, ch);
        chk("pend_done2_cycle", at - t, 505);
        chk("pend_busy_after2", int'(BUSY), 0);
        chk("pend_duty_final", duty_ne(1000), 0);
        wait_done(300, at, ch);
        chk("pend_no_third_done", at, -1);

        // Sign extremes and bit-exact field extraction
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int k = 0; k < 4; k++) mem[sv[k].idx] = sv[k].word;
        req(t);
        wait_done(400, at, ch);
        chk("sign_done_cycle", at - t, 253);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sign_duty[%0d]", sv[k].idx),
                int'(FILTER_DUTY[sv[k].idx]), sv[k].exp_d);
            chk($sformatf("sign_phase[%0d]", sv[k].idx),
                int'(FILTER_PHASE[sv[k].idx]), sv[k].exp_p);
        end

        // Reset mid-LOAD after a prior commit
        for (int i = 0; i < D; i++) mem[i] = pk(5, 0);
        req(t);
        wait_done(400, at, ch);
        chk("abort_prior_duty", int'(FILTER_DUTY[3]), 5);
        req(t);
        goto(t + 100);
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_duty_cleared", duty_ne(0), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_addr", int'(BRAM_ADDR), 0);
        chk("abort_done", int'(DONE), 0);
        wait_done(300, at, ch);
        chk("abort_no_done", at, -1);
        for (int i = 0; i < D; i++) mem[i] = pk(9, -9);
        req(t2);
        wait_done(400, at, ch);
        chk("abort_reload_cycle", at - t2, 253);
        chk("abort_reload_duty", duty_ne(9), 0);
        chk("abort_reload_phase", phase_ne(-9), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
